egress_arbiter: RTL and testbench

Per-destination output stage downstream of the packet filter's four ingress filters. Accepts the four filtered AXI-Stream streams (each carrying `tdest`), selects packets whose `tdest` equals this instance's `PORT_ID`, arbitrates round-robin at packet granularity, and drives one egress AXI-Stream through a 2-entry output buffer. Four instances, one per `PORT_ID` 0..3, form the switch fabric behind the filter.

---
 rtl/egress_arbiter.sv | 174 +++++++++++++++++
 tb/tb_egress_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : egress_arbiter
// Purpose  : Selects packets addressed to PORT_ID from four AXI-Stream inputs,
//            arbitrates round-robin per packet, drives one buffered egress.
// Revision : 1.0
// ============================================================================
module egress_arbiter #(
  parameter int PORT_ID    = 0,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ingress_port_0_tdata,
  input  logic                  ingress_port_0_tvalid,
  input  logic                  ingress_port_0_tlast,
  input  logic [1:0]            ingress_port_0_tdest,
  output logic                  ingress_port_0_tready,
  input  logic [DATA_WIDTH-1:0] ingress_port_1_tdata,
  input  logic                  ingress_port_1_tvalid,
  input  logic                  ingress_port_1_tlast,
  input  logic [1:0]            ingress_port_1_tdest,
  output logic                  ingress_port_1_tready,
  input  logic [DATA_WIDTH-1:0] ingress_port_2_tdata,
  input  logic                  ingress_port_2_tvalid,
  input  logic                  ingress_port_2_tlast,
  input  logic [1:0]            ingress_port_2_tdest,
  output logic                  ingress_port_2_tready,
  input  logic [DATA_WIDTH-1:0] ingress_port_3_tdata,
  input  logic                  ingress_port_3_tvalid,
  input  logic                  ingress_port_3_tlast,
  input  logic [1:0]            ingress_port_3_tdest,
  output logic                  ingress_port_3_tready,
  output logic [DATA_WIDTH-1:0] egress_port_tdata,
  output logic                  egress_port_tvalid,
  output logic                  egress_port_tlast,
  input  logic                  egress_port_tready,
  output logic [1:0]            egress_port_tsrc,
  output logic [15:0]           pkt_count
);

  localparam int NUM_PORTS = 4;
  localparam int DEPTH     = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] in_tdata [NUM_PORTS];
  logic [1:0]            in_tdest [NUM_PORTS];
  logic [NUM_PORTS-1:0]  in_tvalid, in_tlast, in_tready, req;

  assign in_tdata[0] = ingress_port_0_tdata;
  assign in_tdata[1] = ingress_port_1_tdata;
  assign in_tdata[2] = ingress_port_2_tdata;
  assign in_tdata[3] = ingress_port_3_tdata;
  assign in_tdest[0] = ingress_port_0_tdest;
  assign in_tdest[1] = ingress_port_1_tdest;
  assign in_tdest[2] = ingress_port_2_tdest;
  assign in_tdest[3] = ingress_port_3_tdest;
  assign in_tvalid   = {ingress_port_3_tvalid, ingress_port_2_tvalid,
                        ingress_port_1_tvalid, ingress_port_0_tvalid};
  assign in_tlast    = {ingress_port_3_tlast, ingress_port_2_tlast,
                        ingress_port_1_tlast, ingress_port_0_tlast};
  assign ingress_port_0_tready = in_tready[0];
  assign ingress_port_1_tready = in_tready[1];
  assign ingress_port_2_tready = in_tready[2];
  assign ingress_port_3_tready = in_tready[3];

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
      assign req[i] = in_tvalid[i] && (in_tdest[i] == 2'(PORT_ID));
    end
  endgenerate

  logic [1:0]            grant, last_grant, pick;
  logic                  pick_valid;
  logic [1:0]            count;
  logic                  room, accept, pop;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  sel_tvalid, sel_tlast;

  // Search starts just after the previous winner so every input gets a turn.
  always_comb begin
    logic [1:0] cand;
    cand       = '0;
    pick       = last_grant;
    pick_valid = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = last_grant + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  assign sel_tdata  = in_tdata[grant];
  assign sel_tvalid = in_tvalid[grant];
  assign sel_tlast  = in_tlast[grant];
  // Ready depends only on registered count, never on egress_port_tready.
  assign room       = (count != 2'd2);
  assign pop        = (count != 2'd0) && egress_port_tready;

  always_comb begin
    state_next = state;
    in_tready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = LOCKED;
      end
      LOCKED: begin
        in_tready[grant] = room;
        accept           = sel_tvalid && room;
        if (accept && sel_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_valid) grant <= pick;
      if (accept && sel_tlast) last_grant <= grant;
    end
  end

  logic [DATA_WIDTH-1:0] buf_data [DEPTH];
  logic [1:0]            buf_src  [DEPTH];
  logic [DEPTH-1:0]      buf_last;
  logic                  wr_ptr, rd_ptr;
  logic [15:0]           pkt_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        buf_data[j] <= '0;
        buf_src[j]  <= '0;
      end
      buf_last <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      pkt_cnt  <= 16'd0;
    end else begin
      if (accept) begin
        buf_data[wr_ptr] <= sel_tdata;
        buf_src[wr_ptr]  <= grant;
        buf_last[wr_ptr] <= sel_tlast;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(accept) - 2'(pop);
      if (pop && buf_last[rd_ptr]) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign egress_port_tvalid = (count != 2'd0);
  assign egress_port_tdata  = buf_data[rd_ptr];
  assign egress_port_tlast  = buf_last[rd_ptr];
  assign egress_port_tsrc   = buf_src[rd_ptr];
  assign pkt_count          = pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_egress_arbiter.sv
`default_nettype none
// Two arbiter instances (PORT_ID 0 and 2) share four ingress streams; egress
// streams are logged and compared against expected per-source packet order.
module tb_egress_arbiter;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] in_tdata [4];
  logic [1:0]    in_tdest [4];
  logic [3:0]    in_tvalid, in_tlast;
  logic [3:0]    tready0, tready2;
  logic [DW-1:0] e0_tdata, e2_tdata;
  logic          e0_tvalid, e0_tlast, e0_tready, e2_tvalid, e2_tlast, e2_tready;
  logic [1:0]    e0_tsrc, e2_tsrc;
  logic [15:0]   pkt0, pkt2;

  egress_arbiter #(.PORT_ID(0), .DATA_WIDTH(DW)) dut0 (
    .clk(clk), .reset(reset),
    .ingress_port_0_tdata(in_tdata[0]), .ingress_port_0_tvalid(in_tvalid[0]),
    .ingress_port_0_tlast(in_tlast[0]), .ingress_port_0_tdest(in_tdest[0]),
    .ingress_port_0_tready(tready0[0]),
    .ingress_port_1_tdata(in_tdata[1]), .ingress_port_1_tvalid(in_tvalid[1]),
    .ingress_port_1_tlast(in_tlast[1]), .ingress_port_1_tdest(in_tdest[1]),
    .ingress_port_1_tready(tready0[1]),
    .ingress_port_2_tdata(in_tdata[2]), .ingress_port_2_tvalid(in_tvalid[2]),
    .ingress_port_2_tlast(in_tlast[2]), .ingress_port_2_tdest(in_tdest[2]),
    .ingress_port_2_tready(tready0[2]),
    .ingress_port_3_tdata(in_tdata[3]), .ingress_port_3_tvalid(in_tvalid[3]),
    .ingress_port_3_tlast(in_tlast[3]), .ingress_port_3_tdest(in_tdest[3]),
    .ingress_port_3_tready(tready0[3]),
    .egress_port_tdata(e0_tdata), .egress_port_tvalid(e0_tvalid),
    .egress_port_tlast(e0_tlast), .egress_port_tready(e0_tready),
    .egress_port_tsrc(e0_tsrc), .pkt_count(pkt0)
  );

  egress_arbiter #(.PORT_ID(2), .DATA_WIDTH(DW)) dut2 (
    .clk(clk), .reset(reset),
    .ingress_port_0_tdata(in_tdata[0]), .ingress_port_0_tvalid(in_tvalid[0]),
    .ingress_port_0_tlast(in_tlast[0]), .ingress_port_0_tdest(in_tdest[0]),
    .ingress_port_0_tready(tready2[0]),
    .ingress_port_1_tdata(in_tdata[1]), .ingress_port_1_tvalid(in_tvalid[1]),
    .ingress_port_1_tlast(in_tlast[1]), .ingress_port_1_tdest(in_tdest[1]),
    .ingress_port_1_tready(tready2[1]),
    .ingress_port_2_tdata(in_tdata[2]), .ingress_port_2_tvalid(in_tvalid[2]),
    .ingress_port_2_tlast(in_tlast[2]), .ingress_port_2_tdest(in_tdest[2]),
    .ingress_port_2_tready(tready2[2]),
    .ingress_port_3_tdata(in_tdata[3]), .ingress_port_3_tvalid(in_tvalid[3]),
    .ingress_port_3_tlast(in_tlast[3]), .ingress_port_3_tdest(in_tdest[3]),
    .ingress_port_3_tready(tready2[3]),
    .egress_port_tdata(e2_tdata), .egress_port_tvalid(e2_tvalid),
    .egress_port_tlast(e2_tlast), .egress_port_tready(e2_tready),
    .egress_port_tsrc(e2_tsrc), .pkt_count(pkt2)
  );

  typedef struct packed { logic [15:0] data; logic last; logic [1:0] dest; } beat_t;
  typedef struct packed { logic [15:0] data; logic last; logic [1:0] src; int cyc; } obs_t;
  typedef struct { logic [3:0] valid; logic [7:0] dest; logic [3:0] exp0; logic [3:0] exp2; } vec_t;

  beat_t src_q [4][$];
  beat_t exp_q [2][4][$];
  obs_t  log0[$], log2[$];
  vec_t  vecs[7];
  int    cyc_n, n_checks, n_fail, c0;
  int    npk[2];
  bit [3:0] acc;
  int    rdy0_pct, rdy2_pct;
  bit    gaps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int s, input int d, input int len, input logic [15:0] base);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = base + 16'(b);
      bt.last = (b == len - 1);
      bt.dest = 2'(d);
      src_q[s].push_back(bt);
    end
  endtask

  // One clock: retire beats accepted at the last edge, drive, then sample handshakes.
  task automatic step();
    obs_t o;
    @(negedge clk);
    cyc_n++;
    for (int n = 0; n < 4; n++)
      if (acc[n] && src_q[n].size() > 0) void'(src_q[n].pop_front());
    for (int n = 0; n < 4; n++) begin
      if (src_q[n].size() > 0 && !(gaps && $urandom_range(3) == 0)) begin
        in_tvalid[n] = 1'b1;
        in_tdata[n]  = src_q[n][0].data;
        in_tlast[n]  = src_q[n][0].last;
        in_tdest[n]  = src_q[n][0].dest;
      end else begin
        in_tvalid[n] = 1'b0;
        in_tlast[n]  = 1'b0;
      end
    end
    e0_tready = ($urandom_range(99) < rdy0_pct);
    e2_tready = ($urandom_range(99) < rdy2_pct);
    #1;
    check("tready0_onehot", 32'($countones(tready0) <= 1), 1);
    check("tready2_onehot", 32'($countones(tready2) <= 1), 1);
    acc = in_tvalid & (tready0 | tready2);
    if (e0_tvalid && e0_tready) begin
      o.data = e0_tdata; o.last = e0_tlast; o.src = e0_tsrc; o.cyc = cyc_n;
      log0.push_back(o);
    end
    if (e2_tvalid && e2_tready) begin
      o.data = e2_tdata; o.last = e2_tlast; o.src = e2_tsrc; o.cyc = cyc_n;
      log2.push_back(o);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) src_q[n].delete();
    in_tvalid = '0;
    in_tlast  = '0;
    acc       = '0;
    @(negedge clk);
    reset    = 1'b0;
    log0.delete();
    log2.delete();
    gaps     = 1'b0;
    rdy0_pct = 100;
    rdy2_pct = 100;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 &&
                           src_q[2].size() == 0 && src_q[3].size() == 0 &&
                           !e0_tvalid && !e2_tvalid)) begin
      step();
      k++;
    end
    check({name, "_drain_in_time"}, 32'(k < budget), 1);
  endtask

  task automatic compare_log(input obs_t lg[$], input int d);
    logic [1:0] cur;
    bit mid;
    beat_t bt;
    mid = 1'b0;
    cur = '0;
    foreach (lg[i]) begin
      if (mid) check("rnd_no_interleave", 32'(lg[i].src), 32'(cur));
      cur = lg[i].src;
      mid = !lg[i].last;
      check("rnd_beat_expected", 32'(exp_q[d][cur].size() != 0), 1);
      if (exp_q[d][cur].size() != 0) begin
        bt = exp_q[d][cur].pop_front();
        check("rnd_data", 32'(lg[i].data), 32'(bt.data));
        check("rnd_last", 32'(lg[i].last), 32'(bt.last));
      end
    end
    for (int s = 0; s < 4; s++) check("rnd_leftover", exp_q[d][s].size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc_n = 0; acc = '0; gaps = 1'b0;
    rdy0_pct = 100; rdy2_pct = 100;
    e0_tready = 1'b1; e2_tready = 1'b1;
    in_tvalid = '0; in_tlast = '0;
    for (int n = 0; n < 4; n++) begin in_tdata[n] = '0; in_tdest[n] = '0; end

    vecs[0] = '{4'b0000, 8'b00_00_00_00, 4'b0000, 4'b0000};
    vecs[1] = '{4'b1111, 8'b00_00_00_00, 4'b0001, 4'b0000};
    vecs[2] = '{4'b1010, 8'b00_00_00_00, 4'b0010, 4'b0000};
    vecs[3] = '{4'b1100, 8'b10_00_00_00, 4'b0100, 4'b1000};
    vecs[4] = '{4'b0100, 8'b00_11_00_00, 4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 8'b00_11_10_01, 4'b1000, 4'b0010};
    vecs[6] = '{4'b1110, 8'b10_10_10_00, 4'b0000, 4'b0010};

    // Reset values
    do_reset();
    check("rst_e0_tvalid", e0_tvalid, 0);
    check("rst_e0_tdata", e0_tdata, 0);
    check("rst_e0_tlast", e0_tlast, 0);
    check("rst_e0_tsrc", e0_tsrc, 0);
    check("rst_pkt0", pkt0, 0);
    check("rst_tready0", tready0, 0);
    check("rst_e2_tvalid", e2_tvalid, 0);
    check("rst_tready2", tready2, 0);

    // Arbitration from reset: which input gets tready one cycle after request
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int n = 0; n < 4; n++)
        if (vecs[v].valid[n]) send(n, int'(vecs[v].dest[2*n +: 2]), 2, 16'hC000 + 16'(n << 4));
      step();
      step();
      check($sformatf("vec%0d_tready0", v), tready0, vecs[v].exp0);
      check($sformatf("vec%0d_tready2", v), tready2, vecs[v].exp2);
      check($sformatf("vec%0d_e0_idle", v), e0_tvalid, 0);
    end

    // Single packet, input 1 -> PORT_ID 2
    do_reset();
    send(1, 2, 3, 16'h0A01);
    step();
    c0 = cyc_n;
    drain("single", 30);
    check("single_beats", log2.size(), 3);
    foreach (log2[i]) begin
      check("single_data", log2[i].data, 16'h0A01 + 16'(i));
      check("single_last", log2[i].last, 32'(i == 2));
      check("single_tsrc", log2[i].src, 1);
      check("single_latency", log2[i].cyc, c0 + 2 + i);
    end
    check("single_pkt2", pkt2, 1);
    check("single_pkt0", pkt0, 0);
    check("single_no_e0", log0.size(), 0);

    // Destination filtering: tdest 3 is served by neither instance
    do_reset();
    send(2, 3, 2, 16'h3300);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        step();
        seen = seen | tready0[2] | tready2[2] | e0_tvalid | e2_tvalid;
      end
      check("filter_never_ready", seen, 0);
    end
    check("filter_pkt0", pkt0, 0);
    check("filter_no_beats", log0.size() + log2.size(), 0);

    // Round-robin: two 2-beat packets queued on every input
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++)
        send(s, 0, 2, 16'h5000 + 16'(s << 8) + 16'(p << 4));
    drain("rr", 100);
    check("rr_beats", log0.size(), 16);
    foreach (log0[i]) begin
      check("rr_tsrc", log0[i].src, (i / 2) % 4);
      check("rr_data", log0[i].data,
            16'h5000 + 16'(((i / 2) % 4) << 8) + 16'((i / 8) << 4) + 16'(i % 2));
      check("rr_last", log0[i].last, i % 2);
    end
    check("rr_pkt0", pkt0, 8);

    // Backpressure: egress stalled during a 5-beat packet
    do_reset();
    rdy0_pct = 0;
    send(0, 0, 5, 16'h7700);
    repeat (8) step();
    check("bp_accepted", 5 - src_q[0].size(), 2);
    check("bp_tready_low", tready0[0], 0);
    check("bp_egress_valid", e0_tvalid, 1);
    check("bp_none_out", log0.size(), 0);
    rdy0_pct = 100;
    drain("bp", 30);
    check("bp_beats", log0.size(), 5);
    foreach (log0[i]) begin
      check("bp_data", log0[i].data, 16'h7700 + 16'(i));
      check("bp_last", log0[i].last, 32'(i == 4));
    end
    check("bp_pkt0", pkt0, 1);

    // Packet counter wrap
    do_reset();
    force dut0.pkt_cnt = 16'hFFFF;
    step();
    release dut0.pkt_cnt;
    step();
    check("wrap_preload", pkt0, 16'hFFFF);
    send(1, 0, 1, 16'h9901);
    drain("wrap", 20);
    check("wrap_pkt0", pkt0, 16'h0000);
    check("wrap_beats", log0.size(), 1);

    // Reset in the middle of a 4-beat packet
    do_reset();
    send(1, 0, 1, 16'hA100);
    send(1, 0, 4, 16'hA200);
    begin
      int k;
      k = 0;
      while (k < 30 && src_q[1].size() > 2) begin step(); k++; end
      check("midrst_reached", 32'(k < 30), 1);
    end
    do_reset();
    check("midrst_e0_tvalid", e0_tvalid, 0);
    check("midrst_tready0", tready0, 0);
    check("midrst_pkt0", pkt0, 0);
    send(0, 0, 1, 16'hB000);
    send(3, 0, 1, 16'hB300);
    drain("midrst", 30);
    check("midrst_beats", log0.size(), 2);
    if (log0.size() == 2) begin
      check("midrst_first_src", log0[0].src, 0);
      check("midrst_second_src", log0[1].src, 3);
    end

    // Random traffic to both instances against per-source packet queues
    do_reset();
    gaps = 1'b1;
    rdy0_pct = 70;
    rdy2_pct = 60;
    npk[0] = 0;
    npk[1] = 0;
    for (int p = 0; p < 40; p++) begin
      int s, d, len;
      beat_t bt;
      s   = $urandom_range(3);
      d   = $urandom_range(1);
      len = $urandom_range(4, 1);
      for (int b = 0; b < len; b++) begin
        bt.data = 16'($urandom);
        bt.last = (b == len - 1);
        bt.dest = (d == 1) ? 2'd2 : 2'd0;
        src_q[s].push_back(bt);
        exp_q[d][s].push_back(bt);
      end
      npk[d]++;
    end
    drain("rnd", 3000);
    compare_log(log0, 0);
    compare_log(log2, 1);
    check("rnd_pkt0", pkt0, npk[0]);
    check("rnd_pkt2", pkt2, npk[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
